// File: rtl/tx_sched_pkg.sv
// Shared types and default timing for the serial word transmit scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: scheduler state enum, the bit-clock divider the default frame/gap
// lengths are derived from, and a helper that sizes the frame/gap counter.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FRAME  = 2'd2,
        GAP    = 2'd3
    } sched_state_e;

    // clk cycles per bit time on the serial line.
    localparam int BAUD_DIV = 2500;

    // 4 characters x 11 bit times (start, 8 data, parity, stop).
    localparam int FRAME_CYCLES_DEF = 44 * BAUD_DIV;

    // Two idle bit times plus slack for the transmitter's stop-bit handling.
    localparam int GAP_CYCLES_DEF = 2 * BAUD_DIV + 300;

    // Counter wide enough to hold the longer of the two phases without wrap.
    function automatic int cnt_width(input int frame_cycles, input int gap_cycles);
        int longest;
        longest = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/tx_word_scheduler_if.sv
// Requester/transmitter bundle of the word scheduler.
// Latency: n/a (wires only).
// Backpressure: req is held until ack; the transmitter side has none.
//
// Signals: req/req_data from requesters, ack back to them, tx_start/tx_data to
// the transmitter, grant_id/busy as status. master = requester side,
// slave = scheduler side.
interface tx_word_scheduler_if
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_start;
    logic [WORD_W-1:0]         tx_data;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        output req, req_data,
        input  ack, tx_start, tx_data, grant_id, busy
    );

    modport slave (
        input  req, req_data,
        output ack, tx_start, tx_data, grant_id, busy
    );

endinterface

// File: rtl/tx_word_scheduler_rr_arbiter.sv
// Picks one pending requester: round-robin from ptr, or fixed priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports: req (pending bits), ptr (highest-priority index this round),
// grant (one-hot), grant_idx (encoded grant). All zero when no req is set.
// Build option TX_SCHED_PRIORITY_EN: req[0] always wins, ptr is ignored.
module rr_arbiter
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

`ifdef TX_SCHED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
`else
    // Walk the requesters starting at ptr, wrapping past NUM_REQ-1; the first
    // pending one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/tx_word_scheduler.sv
// Shares one serial word transmitter among NUM_REQ requesters.
// Latency: req seen in IDLE -> tx_start/ack/tx_data one cycle later; line owned 1+FRAME+GAP cycles.
// Backpressure: requesters hold req until ack; new requests wait until the line is free again.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carrying
// req/req_data in, ack/tx_start/tx_data/grant_id/busy out, all registered.
// Build option TX_SCHED_PRIORITY_EN: fixed priority (req[0] highest) instead
// of round-robin; timing is the same in both builds.
// The transmitter reports no completion, so the FRAME/GAP countdown here is
// the only record of when the line becomes free.
module tx_word_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WORD_W       = 32,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    tx_word_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(FRAME_CYCLES, GAP_CYCLES);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

    sched_state_e        state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [WORD_W-1:0]   tx_data_q;
    logic [IDX_W-1:0]    grant_id_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                tx_start_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic [WORD_W-1:0]   win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (bus.req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // One-hot mux of the winning requester's word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_data = bus.req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // The requester just served drops to lowest priority next round.
`ifdef TX_SCHED_PRIORITY_EN
    assign rr_ptr_d = '0;
`else
    assign rr_ptr_d = (grant_id_q == IDX_LAST) ? '0 : grant_id_q + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // tx_start and ack are single-cycle pulses raised only on IDLE->LAUNCH.
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        tx_data_q  <= win_data;
                        grant_id_q <= arb_idx;
                        ack_q      <= arb_grant;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= FRAME;
                end
                FRAME: begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q    <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

endmodule
